// File: rtl/image_four2three_unpack.sv
// image_four2three_unpack: drains a 4-byte/pixel FIFO in bursts, drops byte 3,
// emits 24-bit pixels. IMAGE_F2T_SWAP_RB_EN reverses the channel order.
module image_four2three_unpack #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 10,
  parameter int BURST     = 64,
  parameter int PIX_BITS  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PIX_BITS-1:0] pixel_total,
  input  logic [WIDTH-1:0]    fifo_dout,
  input  logic                fifo_M_Valid,
  output logic                fifo_rd_en,
  output logic [ADDR_BITS:0]  M_Count,
  output logic [3*WIDTH-1:0]  pixel_data,
  output logic                pixel_valid,
  input  logic                pixel_ready,
  output logic                busy,
  output logic                done
);

  localparam int MW = ADDR_BITS + 1;
  localparam int PW = 3 * WIDTH;
  localparam logic [PIX_BITS-1:0] BURST_P = PIX_BITS'(BURST);
  localparam logic [MW-1:0] MC_RST = MW'(4 * BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_SETTLE,
    S_FLUSH
  } state_t;

  function automatic logic [PIX_BITS-1:0] clip_burst(
    input logic [PIX_BITS-1:0] rem
  );
    return (rem < BURST_P) ? rem : BURST_P;
  endfunction

  function automatic logic [MW-1:0] bytes_of(
    input logic [PIX_BITS-1:0] n
  );
    logic [PIX_BITS+1:0] b;
    b = {n, 2'b00};
    return MW'(b);
  endfunction

  state_t              state_q, state_d;
  logic [PIX_BITS-1:0] remaining_q, remaining_d;
  logic [PIX_BITS-1:0] burst_len_q, burst_len_d;
  logic [PIX_BITS-1:0] pix_iss_q, pix_iss_d;
  logic [PIX_BITS-1:0] rem_next;
  logic [MW-1:0]       m_count_q, m_count_d;
  logic [1:0]          hold_q, hold_d;
  logic [1:0]          lane_iss_q, lane_iss_d;
  logic [2:0]          inflight_q, inflight_d;
  logic                zero_done_q, zero_done_d;
  logic                rd_dly_q, rd_dly_d;
  logic [1:0]          lane_cap_q, lane_cap_d;
  logic [WIDTH-1:0]    b0_q, b0_d;
  logic [WIDTH-1:0]    b1_q, b1_d;
  logic [WIDTH-1:0]    b2_q, b2_d;
  logic [PW-1:0]       buf_q [4];
  logic [PW-1:0]       buf_d [4];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]          cnt_q, cnt_d;

  logic          rd_en;
  logic          grp_start;
  logic          flush_done;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic [PW-1:0] pix_packed;

`ifdef IMAGE_F2T_SWAP_RB_EN
  assign pix_packed = {b0_q, b1_q, b2_q};
`else
  assign pix_packed = {b2_q, b1_q, b0_q};
`endif

  assign fifo_rd_en  = rd_en;
  assign M_Count     = m_count_q;
  assign pixel_valid = (cnt_q != 3'd0);
  assign pixel_data  = pixel_valid ? buf_q[rd_ptr_q] : '0;
  assign pop         = pixel_valid && pixel_ready;
  assign busy        = (state_q != S_IDLE);
  assign done        = zero_done_q | flush_done;

  // Burst sequencing: threshold, wait, grouped reads, settle, flush
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    m_count_d   = m_count_q;
    pix_iss_d   = pix_iss_q;
    lane_iss_d  = lane_iss_q;
    hold_d      = hold_q;
    zero_done_d = 1'b0;
    rd_en       = 1'b0;
    grp_start   = 1'b0;
    flush_done  = 1'b0;
    rem_next    = remaining_q - burst_len_q;
    credit_ok   = ({1'b0, cnt_q} + {1'b0, inflight_q}) < 4'd4;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pixel_total == '0) begin
            zero_done_d = 1'b1;
          end else begin
            remaining_d = pixel_total;
            burst_len_d = clip_burst(pixel_total);
            m_count_d   = bytes_of(clip_burst(pixel_total));
            pix_iss_d   = '0;
            lane_iss_d  = 2'd0;
            hold_d      = 2'd2;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (hold_q != 2'd0) begin
          hold_d = hold_q - 2'd1;
        end else if (fifo_M_Valid) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (lane_iss_q != 2'd0) begin
          rd_en = 1'b1;
        end else if (pix_iss_q != burst_len_q && credit_ok) begin
          rd_en     = 1'b1;
          grp_start = 1'b1;
        end
        if (rd_en) begin
          lane_iss_d = lane_iss_q + 2'd1;
          if (lane_iss_q == 2'd3) begin
            pix_iss_d = pix_iss_q + PIX_BITS'(1);
            if (pix_iss_d == burst_len_q) begin
              pix_iss_d   = '0;
              remaining_d = rem_next;
              if (rem_next != '0) begin
                burst_len_d = clip_burst(rem_next);
                m_count_d   = bytes_of(clip_burst(rem_next));
                hold_d      = 2'd1;
                state_d     = S_SETTLE;
              end else begin
                state_d = S_FLUSH;
              end
            end
          end
        end
      end
      S_SETTLE: begin
        if (hold_q == 2'd0) begin
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q - 2'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0 && inflight_q == 3'd0) begin
          flush_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte capture: lanes 0..2 stored, lane 3 completes the pixel
  always_comb begin
    rd_dly_d   = rd_en;
    lane_cap_d = lane_cap_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    push       = 1'b0;
    if (rd_dly_q) begin
      lane_cap_d = lane_cap_q + 2'd1;
      case (lane_cap_q)
        2'd0:    b0_d = fifo_dout;
        2'd1:    b1_d = fifo_dout;
        2'd2:    b2_d = fifo_dout;
        default: push = 1'b1;
      endcase
    end
  end

  // Output buffer and in-flight credit tracking
  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    if (push) begin
      buf_d[wr_ptr_q] = pix_packed;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    case ({grp_start, push})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      burst_len_q <= '0;
      pix_iss_q   <= '0;
      m_count_q   <= MC_RST;
      hold_q      <= 2'd0;
      lane_iss_q  <= 2'd0;
      inflight_q  <= 3'd0;
      zero_done_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      lane_cap_q  <= 2'd0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      cnt_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      pix_iss_q   <= pix_iss_d;
      m_count_q   <= m_count_d;
      hold_q      <= hold_d;
      lane_iss_q  <= lane_iss_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
      rd_dly_q    <= rd_dly_d;
      lane_cap_q  <= lane_cap_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_image_four2three_unpack.sv
// tb_image_four2three_unpack: directed bench with a byte FIFO model
// and a negedge monitor for strobes, pixels, handshake stability.
module tb_image_four2three_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] pixel_total = '0;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_M_Valid = 1'b0;
  logic        fifo_rd_en;
  logic [10:0] M_Count;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        busy;
  logic        done;

  image_four2three_unpack dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pixel_total  (pixel_total),
    .fifo_dout    (fifo_dout),
    .fifo_M_Valid (fifo_M_Valid),
    .fifo_rd_en   (fifo_rd_en),
    .M_Count      (M_Count),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int feed_div = 1;
  int cyc_t = 0;
  int mcyc = 0;

  logic [7:0]  fq[$];
  logic [7:0]  src[$];
  logic        rd_s = 1'b0;
  logic [10:0] mc_s = '0;

  int          strobes = 0;
  int          underflow = 0;
  int          early_err = 0;
  int          grp_err = 0;
  int          stab_err = 0;
  int          done_cnt = 0;
  int          lane_mon = 0;
  int          left_mon = 0;
  logic        stall_q = 1'b0;
  logic [23:0] hold_v = '0;
  logic [23:0] rx[$];
  int          burst_mc[$];

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [23:0] exp_pix(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
`ifdef IMAGE_F2T_SWAP_RB_EN
    return {b0, b1, b2};
`else
    return {b2, b1, b0};
`endif
  endfunction

  // FIFO model: 1-cycle read latency, registered M_Valid
  always @(posedge clk) begin
    int occ;
    mcyc++;
    if (rst) begin
      fq.delete();
      src.delete();
      fifo_M_Valid <= 1'b0;
      fifo_dout    <= '0;
    end else begin
      occ = fq.size();
      fifo_M_Valid <= (occ >= int'(mc_s));
      if (rd_s && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (src.size() > 0 && (mcyc % feed_div) == 0)
        fq.push_back(src.pop_front());
    end
  end

  // Monitor sampled on the falling edge
  always @(negedge clk) begin
    rd_s = fifo_rd_en;
    mc_s = M_Count;
    if (rst) begin
      lane_mon = 0;
      left_mon = 0;
      stall_q  = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        strobes++;
        if (fq.size() == 0) underflow++;
        if (left_mon == 0) begin
          burst_mc.push_back(int'(M_Count));
          if (fq.size() < int'(M_Count)) early_err++;
          left_mon = int'(M_Count);
        end
        left_mon--;
        lane_mon = (lane_mon + 1) % 4;
      end else if (lane_mon != 0) begin
        grp_err++;
      end
      if (stall_q && (!pixel_valid || pixel_data !== hold_v)) stab_err++;
      stall_q = pixel_valid && !pixel_ready;
      hold_v  = pixel_data;
      if (pixel_valid && pixel_ready) rx.push_back(pixel_data);
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_t++;
    pixel_ready = (ready_mode != 0) ? ((cyc_t % 5) == 0) : 1'b1;
  endtask

  task automatic clear_mon();
    strobes   = 0;
    underflow = 0;
    early_err = 0;
    grp_err   = 0;
    stab_err  = 0;
    done_cnt  = 0;
    rx.delete();
    burst_mc.delete();
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (done_cnt != 0) break;
      tick();
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (M_Count !== 11'd256) begin
      n_fail++;
      $display("FAIL rst_mcount: got %0d want 256", M_Count);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (M_Count !== 11'd256) begin
      n_fail++;
      $display("FAIL rst_mcount_rel: got %0d want 256", M_Count);
    end
    n_cmp++;
    if (fifo_rd_en !== 1'b0 || pixel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_valid: got %b%b want 00",
               fifo_rd_en, pixel_valid);
    end
    n_cmp++;
    if (pixel_data !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0", pixel_data);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_done: got %b%b want 00", busy, done);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] bytes [8];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    feed_div = 1;
    for (int i = 0; i < 8; i++) src.push_back(bytes[i]);
    for (int i = 0; i < 15; i++) tick();
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd2;
    tick();
    start = 1'b0;
    n_cmp++;
    if (M_Count !== 11'd8) begin
      n_fail++;
      $display("FAIL short_mcount: got %0d want 8", M_Count);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL short_busy: got %b want 1", busy);
    end
    wait_done(300);
    n_cmp++;
    if (strobes != 8) begin
      n_fail++;
      $display("FAIL short_strobes: got %0d want 8", strobes);
    end
    n_cmp++;
    if (rx.size() != 2) begin
      n_fail++;
      $display("FAIL short_count: got %0d want 2", rx.size());
    end else begin
      n_cmp++;
      if (rx[0] !== exp_pix(8'h11, 8'h22, 8'h33)) begin
        n_fail++;
        $display("FAIL short_pix0: got %h want %h",
                 rx[0], exp_pix(8'h11, 8'h22, 8'h33));
      end
      n_cmp++;
      if (rx[1] !== exp_pix(8'h55, 8'h66, 8'h77)) begin
        n_fail++;
        $display("FAIL short_pix1: got %h want %h",
                 rx[1], exp_pix(8'h55, 8'h66, 8'h77));
      end
    end
    n_cmp++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL short_done: got %0d/%b want 1/0", done_cnt, busy);
    end
    n_cmp++;
    if (underflow != 0 || early_err != 0) begin
      n_fail++;
      $display("FAIL short_early: got %0d/%0d want 0/0",
               underflow, early_err);
    end
  endtask

  task automatic test_zero_length();
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd0;
    tick();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got %b/%b want 1/0", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse: got %b want 0", done);
    end
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (strobes != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_strobes: got %0d/%b want 0/0", strobes, busy);
    end
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 12; i++) src.push_back(pat(500 + i));
    for (int i = 0; i < 20; i++) tick();
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;
    pixel_total = 20'd50;
    tick();
    start = 1'b0;
    wait_done(400);
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (rx.size() != 3 || strobes != 12) begin
      n_fail++;
      $display("FAIL busy_count: got %0d pix %0d strobes want 3/12",
               rx.size(), strobes);
    end
    n_cmp++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done: got %0d/%b want 1/0", done_cnt, busy);
    end
    if (rx.size() == 3) begin
      n_cmp++;
      if (rx[2] !== exp_pix(pat(508), pat(509), pat(510))) begin
        n_fail++;
        $display("FAIL busy_pix2: got %h want %h",
                 rx[2], exp_pix(pat(508), pat(509), pat(510)));
      end
    end
  endtask

  task automatic test_multi_burst();
    int bad;
    int want_mc [3];
    want_mc = '{256, 256, 88};
    for (int i = 0; i < 600; i++) src.push_back(pat(i));
    feed_div = 3;
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd150;
    tick();
    start = 1'b0;
    n_cmp++;
    if (M_Count !== 11'd256) begin
      n_fail++;
      $display("FAIL multi_mc0: got %0d want 256", M_Count);
    end
    wait_done(6000);
    feed_div = 1;
    n_cmp++;
    if (burst_mc.size() != 3) begin
      n_fail++;
      $display("FAIL multi_bursts: got %0d want 3", burst_mc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (burst_mc[k] != want_mc[k]) begin
          n_fail++;
          $display("FAIL multi_mc%0d: got %0d want %0d",
                   k, burst_mc[k], want_mc[k]);
        end
      end
    end
    n_cmp++;
    if (strobes != 600) begin
      n_fail++;
      $display("FAIL multi_strobes: got %0d want 600", strobes);
    end
    n_cmp++;
    if (rx.size() != 150) begin
      n_fail++;
      $display("FAIL multi_count: got %0d want 150", rx.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 150; k++)
        if (rx[k] !== exp_pix(pat(4*k), pat(4*k+1), pat(4*k+2))) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL multi_data: got %0d bad want 0", bad);
      end
    end
    n_cmp++;
    if (underflow != 0 || early_err != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL multi_flow: got uf %0d early %0d done %0d want 0/0/1",
               underflow, early_err, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < 40; i++) src.push_back(pat(1000 + i));
    for (int i = 0; i < 50; i++) tick();
    clear_mon();
    ready_mode = 1;
    start = 1'b1;
    pixel_total = 20'd10;
    tick();
    start = 1'b0;
    wait_done(2000);
    ready_mode = 0;
    tick();
    n_cmp++;
    if (rx.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 10", rx.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 10; k++)
        if (rx[k] !== exp_pix(pat(1000 + 4*k), pat(1001 + 4*k),
                              pat(1002 + 4*k))) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL bp_data: got %0d bad want 0", bad);
      end
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d want 0", stab_err);
    end
    n_cmp++;
    if (grp_err != 0 || strobes != 40) begin
      n_fail++;
      $display("FAIL bp_groups: got %0d/%0d want 0/40", grp_err, strobes);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 40; i++) src.push_back(pat(2000 + i));
    for (int i = 0; i < 50; i++) tick();
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (strobes >= 10) break;
      tick();
    end
    n_cmp++;
    if (strobes < 10) begin
      n_fail++;
      $display("FAIL mid_reach: got %0d want >=10", strobes);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (pixel_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: got %b%b%b want 000",
               pixel_valid, busy, fifo_rd_en);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) src.push_back(pat(3000 + i));
    for (int i = 0; i < 15; i++) tick();
    clear_mon();
    start = 1'b1;
    pixel_total = 20'd2;
    tick();
    start = 1'b0;
    wait_done(300);
    n_cmp++;
    if (rx.size() != 2 || strobes != 8) begin
      n_fail++;
      $display("FAIL mid_count: got %0d pix %0d strobes want 2/8",
               rx.size(), strobes);
    end else begin
      n_cmp++;
      if (rx[0] !== exp_pix(pat(3000), pat(3001), pat(3002)) ||
          rx[1] !== exp_pix(pat(3004), pat(3005), pat(3006))) begin
        n_fail++;
        $display("FAIL mid_data: got %h %h want %h %h", rx[0], rx[1],
                 exp_pix(pat(3000), pat(3001), pat(3002)),
                 exp_pix(pat(3004), pat(3005), pat(3006)));
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL mid_done: got %0d want 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_zero_length();
    test_busy_start();
    test_multi_burst();
    test_backpressure();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
